// File: rtl/shifter_pkg.sv
// Shared op encodings, FSM states and op legality for the sequential shifter.
// SEQ_SHIFTER_SRA_EN makes op 100 (arithmetic right shift) legal.
package shifter_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_ROR = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
`ifdef SEQ_SHIFTER_SRA_EN
        return op <= OP_SRA;
`else
        return op <= OP_SRL;
`endif
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle of the sequential shifter.
// master drives requests and consumes results; slave is the shifter.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 16
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] in_cnt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_cnt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_err
    );

    modport slave (
        input  in_valid, in_data, in_cnt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_err
    );

endinterface

// File: rtl/shift_step.sv
// Combinational single step: shifts/rotates i_data by i_amt (0..STEP, bounded by caller).
// With SEQ_SHIFTER_SRA_EN an i_fill port supplies the arithmetic sign bit.
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_amt,
    input  logic [2:0]       i_op,
`ifdef SEQ_SHIFTER_SRA_EN
    input  logic             i_fill,
`endif
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_rol;
    logic [WIDTH-1:0] w_ror;
    logic [WIDTH-1:0] w_sll;
    logic [WIDTH-1:0] w_srl;

    // A shift of WIDTH by the complementary path yields 0, so amt=0 degenerates cleanly.
    assign w_rol = (i_data << i_amt) | (i_data >> (WIDTH - 32'(i_amt)));
    assign w_ror = (i_data >> i_amt) | (i_data << (WIDTH - 32'(i_amt)));
    assign w_sll = i_data << i_amt;
    assign w_srl = i_data >> i_amt;

`ifdef SEQ_SHIFTER_SRA_EN
    localparam logic [WIDTH-1:0] ONES = '1;
    logic [WIDTH-1:0] w_sra;
    assign w_sra = w_srl | (~(ONES >> i_amt) & {WIDTH{i_fill}});
`endif

    always_comb begin
        o_data = i_data;
        case (i_op)
            OP_ROL:  o_data = w_rol;
            OP_SLL:  o_data = w_sll;
            OP_ROR:  o_data = w_ror;
            OP_SRL:  o_data = w_srl;
`ifdef SEQ_SHIFTER_SRA_EN
            OP_SRA:  o_data = w_sra;
`endif
            default: o_data = i_data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: up to STEP positions per clock, valid/ready on both sides.
// Optional SEQ_SHIFTER_SRA_EN enables op 100 (arithmetic right shift).
module seq_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic          clk,
    input  logic          rst,
    seq_shifter_if.slave  bus
);

    localparam int unsigned      CNT_W  = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("seq_shifter: WIDTH must be a power of 2 and >= 4");
    end
    if (STEP < 1 || STEP > WIDTH / 2 || (STEP & (STEP - 1)) != 0) begin : g_bad_step
        $error("seq_shifter: STEP must be a power of 2 in 1..WIDTH/2");
    end

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_data_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic [2:0]       r_op;
    logic [2:0]       w_op_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_amt;
    logic [WIDTH-1:0] w_step_data;
    logic             w_legal;

`ifdef SEQ_SHIFTER_SRA_EN
    logic             r_sign;
    logic             w_sign_nxt;
`endif

    assign w_amt   = (r_rem > STEP_C) ? STEP_C : r_rem;
    assign w_legal = op_legal(bus.in_op);

    shift_step #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shift_step (
        .i_data (r_data),
        .i_amt  (w_amt),
        .i_op   (r_op),
`ifdef SEQ_SHIFTER_SRA_EN
        .i_fill (r_sign),
`endif
        .o_data (w_step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_data_nxt    = r_data;
        w_rem_nxt     = r_rem;
        w_op_nxt      = r_op;
        w_err_nxt     = r_err;
`ifdef SEQ_SHIFTER_SRA_EN
        w_sign_nxt    = r_sign;
`endif
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;

        unique case (r_state)
            StIdle: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_data_nxt  = bus.in_data;
                    w_op_nxt    = bus.in_op;
                    w_err_nxt   = ~w_legal;
                    // Illegal ops pass through: zero count gives a single idle step.
                    w_rem_nxt   = w_legal ? bus.in_cnt : '0;
`ifdef SEQ_SHIFTER_SRA_EN
                    w_sign_nxt  = bus.in_data[WIDTH-1];
`endif
                    w_state_nxt = StShift;
                end
            end
            StShift: begin
                w_data_nxt = w_step_data;
                w_rem_nxt  = r_rem - w_amt;
                if (r_rem == w_amt) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_rem  <= '0;
            r_op   <= OP_ROL;
            r_err  <= 1'b0;
`ifdef SEQ_SHIFTER_SRA_EN
            r_sign <= 1'b0;
`endif
        end else begin
            r_data <= w_data_nxt;
            r_rem  <= w_rem_nxt;
            r_op   <= w_op_nxt;
            r_err  <= w_err_nxt;
`ifdef SEQ_SHIFTER_SRA_EN
            r_sign <= w_sign_nxt;
`endif
        end
    end

    assign bus.out_data = r_data;
    assign bus.out_zero = (r_data == '0);
    assign bus.out_err  = r_err;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one STEP=1 and one STEP=4 instance on a shared driver.
module tb_seq_shifter;
    import shifter_pkg::*;

    logic        clk;
    logic        rst;
    logic        sel;      // 0 -> STEP=1 instance, 1 -> STEP=4 instance
    logic        valid;
    logic [15:0] data;
    logic [3:0]  cnt;
    logic [2:0]  op;
    logic        out_rdy;

    logic        o_valid, o_ready, o_zero, o_err;
    logic [15:0] o_data;

    logic [15:0] res_data;
    logic        res_zero, res_err, res_rdy_low;
    int          res_lat;
    int          errs, checks;

    seq_shifter_if #(.WIDTH(16)) if1 ();
    seq_shifter_if #(.WIDTH(16)) if4 ();

    assign if1.in_valid  = valid & ~sel;
    assign if4.in_valid  = valid & sel;
    assign if1.in_data   = data;
    assign if4.in_data   = data;
    assign if1.in_cnt    = cnt;
    assign if4.in_cnt    = cnt;
    assign if1.in_op     = op;
    assign if4.in_op     = op;
    assign if1.out_ready = out_rdy & ~sel;
    assign if4.out_ready = out_rdy & sel;

    assign o_valid = sel ? if4.out_valid : if1.out_valid;
    assign o_ready = sel ? if4.in_ready  : if1.in_ready;
    assign o_data  = sel ? if4.out_data  : if1.out_data;
    assign o_zero  = sel ? if4.out_zero  : if1.out_zero;
    assign o_err   = sel ? if4.out_err   : if1.out_err;

    seq_shifter #(.WIDTH(16), .STEP(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_shifter #(.WIDTH(16), .STEP(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issues one request and waits (bounded) for out_valid; leaves the result unconsumed.
    task automatic do_req(input logic s, input logic [15:0] d, input logic [3:0] c,
                          input logic [2:0] o);
        sel = s; valid = 1'b1; data = d; cnt = c; op = o;
        @(posedge clk); #1;
        valid = 1'b0; data = 16'hDEAD; cnt = 4'hF; op = 3'b111;
        res_rdy_low = 1'b1;
        res_lat = 0;
        while (res_lat < 40) begin
            if (o_ready) res_rdy_low = 1'b0;
            @(posedge clk); #1;
            res_lat++;
            if (o_valid) break;
        end
        res_data = o_data; res_zero = o_zero; res_err = o_err;
    endtask

    task automatic consume();
        out_rdy = 1'b1;
        @(posedge clk); #1;
        out_rdy = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b want 1", o_ready); end
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid: got %b want 0", o_valid); end
        checks++; if (o_data !== 16'h0) begin errs++; $display("FAIL rst_out_data: got %h want 0000", o_data); end
        checks++; if (o_zero !== 1'b1) begin errs++; $display("FAIL rst_out_zero: got %b want 1", o_zero); end
        checks++; if (o_err !== 1'b0) begin errs++; $display("FAIL rst_out_err: got %b want 0", o_err); end
        checks++; if (if4.in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready4: got %b want 1", if4.in_ready); end
    endtask

    task automatic test_rol_step1();
        do_req(1'b0, 16'h8001, 4'd1, OP_ROL);
        checks++; if (res_data !== 16'h0003) begin errs++; $display("FAIL rol_data: got %h want 0003", res_data); end
        checks++; if (res_lat !== 1) begin errs++; $display("FAIL rol_lat: got %0d want 1", res_lat); end
        checks++; if (res_zero !== 1'b0) begin errs++; $display("FAIL rol_zero: got %b want 0", res_zero); end
        checks++; if (res_err !== 1'b0) begin errs++; $display("FAIL rol_err: got %b want 0", res_err); end
        consume();
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL rol_consumed_valid: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rol_consumed_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_sll_long();
        do_req(1'b0, 16'h0001, 4'd15, OP_SLL);
        checks++; if (res_data !== 16'h8000) begin errs++; $display("FAIL sll15_data: got %h want 8000", res_data); end
        checks++; if (res_lat !== 15) begin errs++; $display("FAIL sll15_lat: got %0d want 15", res_lat); end
        checks++; if (res_rdy_low !== 1'b1) begin errs++; $display("FAIL sll15_ready_low: got %b want 1", res_rdy_low); end
        consume();
    endtask

    task automatic test_step4();
        do_req(1'b1, 16'h0001, 4'd4, OP_ROR);
        checks++; if (res_data !== 16'h1000) begin errs++; $display("FAIL ror4_data: got %h want 1000", res_data); end
        checks++; if (res_lat !== 1) begin errs++; $display("FAIL ror4_lat: got %0d want 1", res_lat); end
        consume();
        do_req(1'b1, 16'h8000, 4'd15, OP_SRL);
        checks++; if (res_data !== 16'h0001) begin errs++; $display("FAIL srl15_data: got %h want 0001", res_data); end
        checks++; if (res_lat !== 4) begin errs++; $display("FAIL srl15_lat: got %0d want 4", res_lat); end
        consume();
        do_req(1'b1, 16'h0001, 4'd1, OP_SRL);
        checks++; if (res_data !== 16'h0000) begin errs++; $display("FAIL srl1_data: got %h want 0000", res_data); end
        checks++; if (res_zero !== 1'b1) begin errs++; $display("FAIL srl1_zero: got %b want 1", res_zero); end
        checks++; if (res_lat !== 1) begin errs++; $display("FAIL srl1_lat: got %0d want 1", res_lat); end
        consume();
    endtask

    task automatic test_backpressure();
        do_req(1'b0, 16'hABCD, 4'd0, OP_SLL);
        checks++; if (res_data !== 16'hABCD) begin errs++; $display("FAIL cnt0_data: got %h want abcd", res_data); end
        checks++; if (res_lat !== 1) begin errs++; $display("FAIL cnt0_lat: got %0d want 1", res_lat); end
        valid = 1'b1; data = 16'h5555; cnt = 4'd1; op = OP_SLL;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (o_valid !== 1'b1) begin errs++; $display("FAIL bp_valid[%0d]: got %b want 1", i, o_valid); end
            checks++; if (o_data !== 16'hABCD) begin errs++; $display("FAIL bp_data[%0d]: got %h want abcd", i, o_data); end
            checks++; if (o_ready !== 1'b0) begin errs++; $display("FAIL bp_ready[%0d]: got %b want 0", i, o_ready); end
        end
        valid = 1'b0;
        consume();
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL bp_release_valid: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_release_ready: got %b want 1", o_ready); end
        @(posedge clk); #1;
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL bp_idle_ready: got %b want 1", o_ready); end
    endtask

    task automatic test_sra_illegal();
        logic [15:0] exp_d;
        logic        exp_e;
        int          exp_l;
`ifdef SEQ_SHIFTER_SRA_EN
        exp_d = 16'hF800; exp_e = 1'b0; exp_l = 4;
`else
        exp_d = 16'h8000; exp_e = 1'b1; exp_l = 1;
`endif
        do_req(1'b0, 16'h8000, 4'd4, OP_SRA);
        checks++; if (res_data !== exp_d) begin errs++; $display("FAIL sra_data: got %h want %h", res_data, exp_d); end
        checks++; if (res_err !== exp_e) begin errs++; $display("FAIL sra_err: got %b want %b", res_err, exp_e); end
        checks++; if (res_lat !== exp_l) begin errs++; $display("FAIL sra_lat: got %0d want %0d", res_lat, exp_l); end
        consume();
        do_req(1'b1, 16'h1234, 4'd3, 3'b111);
        checks++; if (res_data !== 16'h1234) begin errs++; $display("FAIL op7_data: got %h want 1234", res_data); end
        checks++; if (res_err !== 1'b1) begin errs++; $display("FAIL op7_err: got %b want 1", res_err); end
        checks++; if (res_lat !== 1) begin errs++; $display("FAIL op7_lat: got %0d want 1", res_lat); end
        consume();
        do_req(1'b1, 16'h00F0, 4'd4, OP_SRL);
        checks++; if (res_err !== 1'b0) begin errs++; $display("FAIL err_clear: got %b want 0", res_err); end
        checks++; if (res_data !== 16'h000F) begin errs++; $display("FAIL srl4_data: got %h want 000f", res_data); end
        consume();
    endtask

    task automatic test_reset_midop();
        sel = 1'b0; valid = 1'b1; data = 16'h0001; cnt = 4'd12; op = OP_SLL;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", o_ready); end
        checks++; if (o_data !== 16'h0) begin errs++; $display("FAIL midrst_data: got %h want 0000", o_data); end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (13) begin
            @(posedge clk); #1;
        end
        checks++; if (o_valid !== 1'b0) begin errs++; $display("FAIL midrst_stale: got %b want 0", o_valid); end
        checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL midrst_after_ready: got %b want 1", o_ready); end
        do_req(1'b0, 16'h0003, 4'd2, OP_SLL);
        checks++; if (res_data !== 16'h000C) begin errs++; $display("FAIL postrst_data: got %h want 000c", res_data); end
        checks++; if (res_lat !== 2) begin errs++; $display("FAIL postrst_lat: got %0d want 2", res_lat); end
        consume();
    endtask

    initial begin
        errs = 0; checks = 0;
        rst = 1'b1; sel = 1'b0; valid = 1'b0; data = '0; cnt = '0; op = '0; out_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_rol_step1();
        test_sll_long();
        test_step4();
        test_backpressure();
        test_sra_illegal();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
